alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two, 2..8).
REQ-002 The block SHALL have parameter SETTLE, default 2, meaning cycles ALU operands are held before the result is captured (>=1).
REQ-003 Ports SHALL be, one per line (name  direction  width  meaning):
  clk_i  input  1  single clock, rising edge
  rst_i  input  1  reset, asynchronous, active-high
  cmd_valid_i  input  1  command offered
  cmd_ready_o  output  1  command accepted when high with cmd_valid_i
  cmd_op_i  input  3  opcode: 000 add, 001 sub, 010 mul, 011 div, 100 mod
  cmd_a_i  input  8  operand A
  cmd_b_i  input  8  operand B
  alu_data0_o  output  8  operand A to ALU
  alu_data1_o  output  8  operand B to ALU
  alu_ctrl_o  output  4  ALU control code, {1'b0, opcode}
  alu_result_i  input  8  ALU combinational result
  rsp_valid_o  output  1  response available
  rsp_ready_i  input  1  response consumed when high with rsp_valid_o
  rsp_data_o  output  8  captured result
  rsp_op_o  output  3  opcode of this response
  rsp_err_o  output  1  illegal opcode or divide/modulo by zero
  busy_o  output  1  FSM not IDLE or FIFO non-empty
  count_o  output  4  FIFO occupancy, 0..DEPTH

Function
REQ-004 Push SHALL occur on a rising edge with cmd_valid_i && cmd_ready_o; cmd_ready_o SHALL equal (count_o < DEPTH), derived from registered count only.
REQ-005 When FIFO is full, cmd_ready_o SHALL be 0 even if a pop occurs in the same cycle; a simultaneous push and pop when not full SHALL leave count_o unchanged.
REQ-006 FSM states SHALL be IDLE, EXEC, RESP; pop SHALL occur only in IDLE with count_o > 0.
REQ-007 On pop, legal command (opcode <= 100, and not (opcode 011/100 with B = 0x00)): load alu_data0_o, alu_data1_o, alu_ctrl_o from entry, go to EXEC.
REQ-008 On pop, illegal command: alu_* outputs unchanged, rsp_data_o = 0x00, rsp_err_o = 1, go directly to RESP.
REQ-009 EXEC SHALL last exactly SETTLE cycles; on its last edge alu_result_i SHALL be captured into rsp_data_o with rsp_err_o = 0, then RESP.
REQ-010 alu_data0_o, alu_data1_o, alu_ctrl_o SHALL be stable throughout EXEC and hold last issued values outside EXEC.
REQ-011 RESP SHALL assert rsp_valid_o; rsp_data_o, rsp_op_o, rsp_err_o SHALL be stable until the rsp_valid_o && rsp_ready_i edge, which returns the FSM to IDLE.
REQ-012 Legal-command latency, idle block with empty FIFO: rsp_valid_o SHALL be high in the cycle after edge N+1+SETTLE, where N is the acceptance edge; illegal-command latency is edge N+1.
REQ-013 Responses SHALL be returned in command acceptance order; no command SHALL be dropped or duplicated.
REQ-014 FIFO pointers SHALL wrap modulo DEPTH.
REQ-015 Arithmetic results SHALL be the ALU's 8-bit values unmodified; no width extension or saturation inside this block.

Reset
REQ-016 While rst_i is high, immediately and independent of clk_i: FIFO emptied, FSM = IDLE, count_o = 0, rsp_valid_o = 0, rsp_data_o = 0x00, rsp_op_o = 000, rsp_err_o = 0, alu_data0_o = 0x00, alu_data1_o = 0x00, alu_ctrl_o = 0000, busy_o = 0, cmd_ready_o = 1.
REQ-017 Reset during EXEC or RESP SHALL discard the in-flight and queued commands; no response SHALL appear for them after release.

Verification
REQ-018 Reset pulse, then release -> cmd_ready_o = 1, rsp_valid_o = 0, count_o = 0, all alu_* outputs 0.
REQ-019 SETTLE=2, ALU model attached, push op 000 A=0x05 B=0x03 -> rsp_valid_o high in the cycle after edge N+3, rsp_data_o = 0x08, rsp_err_o = 0, rsp_op_o = 000.
REQ-020 Push op 011 A=0x10 B=0x00 -> rsp_err_o = 1, rsp_data_o = 0x00 at edge N+1; alu_ctrl_o never shows 0011.
REQ-021 Push op 101 -> rsp_err_o = 1, rsp_op_o = 101.
REQ-022 rsp_ready_i = 0, push 6 commands back-to-back -> first popped, count_o reaches 4, 6th stalls with cmd_ready_o = 0; raising rsp_ready_i yields 6 in-order responses with correct values.
REQ-023 Assert rst_i mid-EXEC with 3 queued -> outputs clear within the same cycle; after release, 20 idle cycles show no rsp_valid_o.

Source files
------------

// File: rtl/alu_sequencer.sv
// Command FIFO feeding an external combinational ALU: pops one command at a time,
// holds operands for SETTLE cycles, captures the result and hands it back in order.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a queued command; pops when FIFO non-empty
// ST_EXEC   | operands driven to ALU, settle down-counter running
// ST_RESP   | response presented, waiting for rsp_ready_i
module alu_sequencer #(
   parameter int DEPTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [2:0] cmd_op_i,
   input  logic [7:0] cmd_a_i,
   input  logic [7:0] cmd_b_i,
   output logic [7:0] alu_data0_o,
   output logic [7:0] alu_data1_o,
   output logic [3:0] alu_ctrl_o,
   input  logic [7:0] alu_result_i,
   output logic       rsp_valid_o,
   input  logic       rsp_ready_i,
   output logic [7:0] rsp_data_o,
   output logic [2:0] rsp_op_o,
   output logic       rsp_err_o,
   output logic       busy_o,
   output logic [3:0] count_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [2:0]    fifo_op [DEPTH];
   logic [7:0]    fifo_a  [DEPTH];
   logic [7:0]    fifo_b  [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [3:0]    count_q;

   logic [SW-1:0] settle_q;
   logic [7:0]    alu_a_q, alu_b_q;
   logic [2:0]    alu_op_q;
   logic [7:0]    rsp_data_q;
   logic [2:0]    rsp_op_q;
   logic          rsp_err_q;

   logic          push, pop;
   logic [2:0]    head_op;
   logic [7:0]    head_a, head_b;
   logic          head_legal;
   logic          settle_done;

   assign cmd_ready_o = (count_q < 4'(DEPTH));
   assign push        = cmd_valid_i && cmd_ready_o;
   assign pop         = (state_q == ST_IDLE) && (count_q != 4'd0);

   assign head_op     = fifo_op[rd_ptr_q];
   assign head_a      = fifo_a[rd_ptr_q];
   assign head_b      = fifo_b[rd_ptr_q];
   // Divide/modulo by zero never reaches the ALU; it is answered as an error.
   assign head_legal  = (head_op <= 3'd4) &&
                        !(((head_op == 3'd3) || (head_op == 3'd4)) && (head_b == 8'h00));
   assign settle_done = (settle_q == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pop) state_d = head_legal ? ST_EXEC : ST_RESP;
         ST_EXEC: if (settle_done) state_d = ST_RESP;
         ST_RESP: if (rsp_ready_i) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Storage carries no reset; emptiness is tracked by the pointers and count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_op[wr_ptr_q] <= cmd_op_i;
         fifo_a[wr_ptr_q]  <= cmd_a_i;
         fifo_b[wr_ptr_q]  <= cmd_b_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= 4'd0;
         settle_q   <= '0;
         alu_a_q    <= 8'h00;
         alu_b_q    <= 8'h00;
         alu_op_q   <= 3'd0;
         rsp_data_q <= 8'h00;
         rsp_op_q   <= 3'd0;
         rsp_err_q  <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);

         case ({push, pop})
            2'b10:   count_q <= count_q + 4'd1;
            2'b01:   count_q <= count_q - 4'd1;
            default: count_q <= count_q;
         endcase

         if (pop) begin
            if (head_legal) begin
               alu_a_q  <= head_a;
               alu_b_q  <= head_b;
               alu_op_q <= head_op;
               settle_q <= SW'(SETTLE - 1);
            end else begin
               rsp_data_q <= 8'h00;
               rsp_op_q   <= head_op;
               rsp_err_q  <= 1'b1;
            end
         end

         // Response fields update only on RESP entry so they never glitch mid-response.
         if (state_q == ST_EXEC) begin
            if (settle_done) begin
               rsp_data_q <= alu_result_i;
               rsp_op_q   <= alu_op_q;
               rsp_err_q  <= 1'b0;
            end else begin
               settle_q <= settle_q - SW'(1);
            end
         end
      end
   end

   assign alu_data0_o = alu_a_q;
   assign alu_data1_o = alu_b_q;
   assign alu_ctrl_o  = {1'b0, alu_op_q};
   assign rsp_valid_o = (state_q == ST_RESP);
   assign rsp_data_o  = rsp_data_q;
   assign rsp_op_o    = rsp_op_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = (state_q != ST_IDLE) || (count_q != 4'd0);
   assign count_o     = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: constant vector table, hand-timed corner sequences,
// and randomized traffic scored against an arithmetic reference queue.
module tb_alu_sequencer;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [2:0] cmd_op_i = 3'd0;
   logic [7:0] cmd_a_i = 8'h00;
   logic [7:0] cmd_b_i = 8'h00;
   logic [7:0] alu_data0_o, alu_data1_o;
   logic [3:0] alu_ctrl_o;
   logic [7:0] alu_result_i;
   logic       rsp_valid_o;
   logic       rsp_ready_i = 1'b0;
   logic [7:0] rsp_data_o;
   logic [2:0] rsp_op_o;
   logic       rsp_err_o;
   logic       busy_o;
   logic [3:0] count_o;

   int n_pass  = 0;
   int n_total = 0;

   alu_sequencer #(.DEPTH(4), .SETTLE(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_op_i(cmd_op_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
      .alu_data0_o(alu_data0_o), .alu_data1_o(alu_data1_o), .alu_ctrl_o(alu_ctrl_o),
      .alu_result_i(alu_result_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_data_o(rsp_data_o), .rsp_op_o(rsp_op_o), .rsp_err_o(rsp_err_o),
      .busy_o(busy_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   // External combinational ALU
   always_comb begin
      alu_result_i = 8'h00;
      case (alu_ctrl_o)
         4'd0: alu_result_i = alu_data0_o + alu_data1_o;
         4'd1: alu_result_i = alu_data0_o - alu_data1_o;
         4'd2: alu_result_i = alu_data0_o * alu_data1_o;
         4'd3: alu_result_i = (alu_data1_o != 8'h00) ? alu_data0_o / alu_data1_o : 8'hFF;
         4'd4: alu_result_i = (alu_data1_o != 8'h00) ? alu_data0_o % alu_data1_o : 8'hFF;
         default: alu_result_i = 8'h00;
      endcase
   end

   logic div_ctrl_seen = 1'b0;
   logic mon_div = 1'b0;
   always @(negedge clk_i) if (mon_div && alu_ctrl_o == 4'b0011) div_ctrl_seen = 1'b1;

   typedef struct {
      logic [2:0] op;
      logic [7:0] data;
      logic       err;
   } rsp_t;
   rsp_t sbq[$];

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] data;
      logic       err;
   } vec_t;
   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic rsp_t ref_rsp(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      rsp_t r;
      int ia, ib, res;
      ia = int'(a);
      ib = int'(b);
      res = 0;
      r.op = op;
      r.err = 1'b0;
      case (op)
         3'd0: res = (ia + ib) % 256;
         3'd1: res = (ia - ib + 256) % 256;
         3'd2: res = (ia * ib) % 256;
         3'd3: if (ib == 0) r.err = 1'b1; else res = ia / ib;
         3'd4: if (ib == 0) r.err = 1'b1; else res = ia % ib;
         default: r.err = 1'b1;
      endcase
      r.data = r.err ? 8'h00 : 8'(res);
      return r;
   endfunction

   task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      int n = 0;
      @(negedge clk_i);
      cmd_valid_i = 1'b1;
      cmd_op_i = op;
      cmd_a_i = a;
      cmd_b_i = b;
      while (!cmd_ready_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      if (!cmd_ready_o) begin
         chk("push_timeout", 32'(cmd_ready_o), 32'd1);
         cmd_valid_i = 1'b0;
      end else begin
         @(posedge clk_i);
         #1 cmd_valid_i = 1'b0;
      end
   endtask

   task automatic wait_valid(output logic ok);
      int n = 0;
      @(negedge clk_i);
      while (!rsp_valid_o && n < 200) begin
         @(negedge clk_i);
         n++;
      end
      ok = rsp_valid_o;
      if (!ok) chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
   endtask

   task automatic handshake();
      rsp_ready_i = 1'b1;
      @(posedge clk_i);
      #1 rsp_ready_i = 1'b0;
   endtask

   task automatic get_rsp(input string nm, input logic [2:0] eop, input logic [7:0] edata, input logic eerr);
      logic ok;
      wait_valid(ok);
      if (ok) begin
         chk({nm, "_data"}, 32'(rsp_data_o), 32'(edata));
         chk({nm, "_err"}, 32'(rsp_err_o), 32'(eerr));
         chk({nm, "_op"}, 32'(rsp_op_o), 32'(eop));
         handshake();
      end
   endtask

   task automatic get_rsp_sb(input string nm, input int max_delay);
      logic ok;
      rsp_t e;
      wait_valid(ok);
      if (ok) begin
         repeat ($urandom_range(max_delay, 0)) @(negedge clk_i);
         if (sbq.size() == 0) begin
            chk({nm, "_unexpected"}, 32'(rsp_valid_o), 32'd0);
         end else begin
            e = sbq.pop_front();
            chk({nm, "_data"}, 32'(rsp_data_o), 32'(e.data));
            chk({nm, "_err"}, 32'(rsp_err_o), 32'(e.err));
            chk({nm, "_op"}, 32'(rsp_op_o), 32'(e.op));
         end
         handshake();
      end
   endtask

   task automatic push_sb(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      push(op, a, b);
      sbq.push_back(ref_rsp(op, a, b));
   endtask

   initial begin
      logic ok;
      int seen;

      vecs[0]  = '{3'd0, 8'h05, 8'h03, 8'h08, 1'b0};
      vecs[1]  = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0};
      vecs[2]  = '{3'd2, 8'h10, 8'h11, 8'h10, 1'b0};
      vecs[3]  = '{3'd3, 8'h64, 8'h07, 8'h0E, 1'b0};
      vecs[4]  = '{3'd4, 8'h64, 8'h07, 8'h02, 1'b0};
      vecs[5]  = '{3'd3, 8'h10, 8'h00, 8'h00, 1'b1};
      vecs[6]  = '{3'd4, 8'h33, 8'h00, 8'h00, 1'b1};
      vecs[7]  = '{3'd5, 8'h01, 8'h02, 8'h00, 1'b1};
      vecs[8]  = '{3'd7, 8'hAA, 8'h55, 8'h00, 1'b1};
      vecs[9]  = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b0};
      vecs[10] = '{3'd2, 8'hFF, 8'hFF, 8'h01, 1'b0};
      vecs[11] = '{3'd3, 8'hFF, 8'h01, 8'hFF, 1'b0};

      // Reset values, both during reset and after release
      #12;
      chk("rst_ready", 32'(cmd_ready_o), 32'd1);
      chk("rst_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("rel_ready", 32'(cmd_ready_o), 32'd1);
      chk("rel_valid", 32'(rsp_valid_o), 32'd0);
      chk("rel_count", 32'(count_o), 32'd0);
      chk("rel_alu", {8'h00, alu_data0_o, alu_data1_o, 4'h0, alu_ctrl_o}, 32'd0);

      // Legal-command latency: valid first seen after edge N+3
      push(3'd0, 8'h05, 8'h03);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk_i);
         chk($sformatf("lat_add_cyc%0d", k), 32'(rsp_valid_o), (k == 4) ? 32'd1 : 32'd0);
      end
      chk("lat_add_data", 32'(rsp_data_o), 32'h08);
      chk("lat_add_err", 32'(rsp_err_o), 32'd0);
      chk("lat_add_op", 32'(rsp_op_o), 32'd0);
      handshake();

      // Divide by zero: answered at edge N+1, ALU never sees opcode 011
      div_ctrl_seen = 1'b0;
      mon_div = 1'b1;
      push(3'd3, 8'h10, 8'h00);
      @(negedge clk_i);
      chk("dz_cyc1", 32'(rsp_valid_o), 32'd0);
      @(negedge clk_i);
      chk("dz_cyc2", 32'(rsp_valid_o), 32'd1);
      chk("dz_err", 32'(rsp_err_o), 32'd1);
      chk("dz_data", 32'(rsp_data_o), 32'h00);
      chk("dz_alu_a_held", 32'(alu_data0_o), 32'h05);
      handshake();
      repeat (3) @(negedge clk_i);
      mon_div = 1'b0;
      chk("dz_no_div_ctrl", 32'(div_ctrl_seen), 32'd0);

      // Illegal opcode
      push(3'd5, 8'h12, 8'h34);
      get_rsp("illop", 3'd5, 8'h00, 1'b1);

      // Vector table
      for (int i = 0; i < 12; i++) begin
         push(vecs[i].op, vecs[i].a, vecs[i].b);
         get_rsp($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].err);
      end

      // Backpressure: five fill the block, the sixth stalls until responses drain
      rsp_ready_i = 1'b0;
      push_sb(3'd0, 8'h01, 8'h02);
      push_sb(3'd1, 8'h10, 8'h20);
      push_sb(3'd2, 8'h07, 8'h06);
      push_sb(3'd3, 8'h50, 8'h00);
      push_sb(3'd4, 8'h50, 8'h09);
      @(negedge clk_i);
      chk("full_count", 32'(count_o), 32'd4);
      chk("full_ready", 32'(cmd_ready_o), 32'd0);
      chk("full_valid", 32'(rsp_valid_o), 32'd1);
      fork
         push_sb(3'd6, 8'h33, 8'h44);
         for (int i = 0; i < 6; i++) get_rsp_sb($sformatf("bp%0d", i), 0);
      join
      chk("bp_sb_empty", 32'(sbq.size()), 32'd0);

      // Reset while executing with three commands queued
      push(3'd0, 8'h01, 8'h01);
      wait_valid(ok);
      push(3'd2, 8'h03, 8'h03);
      push(3'd0, 8'h04, 8'h04);
      push(3'd1, 8'h05, 8'h05);
      push(3'd0, 8'h06, 8'h06);
      @(negedge clk_i);
      chk("pre_rst_count", 32'(count_o), 32'd4);
      handshake();
      @(negedge clk_i);
      @(negedge clk_i);
      chk("exec_busy", 32'(busy_o), 32'd1);
      chk("exec_count", 32'(count_o), 32'd3);
      chk("exec_ctrl", 32'(alu_ctrl_o), 32'd2);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_count", 32'(count_o), 32'd0);
      chk("mid_rst_valid", 32'(rsp_valid_o), 32'd0);
      chk("mid_rst_ready", 32'(cmd_ready_o), 32'd1);
      chk("mid_rst_busy", 32'(busy_o), 32'd0);
      chk("mid_rst_alu", {8'h00, alu_data0_o, alu_data1_o, 4'h0, alu_ctrl_o}, 32'd0);
      chk("mid_rst_rsp", {20'h0, rsp_data_o, rsp_op_o, rsp_err_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      rsp_ready_i = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk_i);
         if (rsp_valid_o) seen++;
      end
      chk("post_rst_no_rsp", 32'(seen), 32'd0);
      chk("post_rst_count", 32'(count_o), 32'd0);
      rsp_ready_i = 1'b0;
      sbq.delete();

      // Randomized traffic against the reference queue
      fork
         for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [7:0] a, b;
            op = 3'($urandom_range(7, 0));
            a  = 8'($urandom);
            b  = ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom);
            push_sb(op, a, b);
         end
         for (int i = 0; i < 40; i++) get_rsp_sb($sformatf("rnd%0d", i), 3);
      join
      chk("rnd_sb_empty", 32'(sbq.size()), 32'd0);
      @(negedge clk_i);
      chk("end_busy", 32'(busy_o), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
